// File: rtl/mul_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: op codes, FSM states
// and the partial-product shift table.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_CORRECT,
        ST_DONE
    } mul_state_t;

    // Bit offset of partial product k inside the 64-bit sum.
    function automatic logic [5:0] pp_shift(input logic [1:0] k);
        logic [5:0] sh;
        case (k)
            2'd0:    sh = 6'd0;
            2'd1:    sh = 6'd16;
            2'd2:    sh = 6'd16;
            default: sh = 6'd32;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul16_cell.sv
// 16x16 unsigned multiplier with MUL_LAT registered stages; the product of
// operands presented in cycle t appears on p in cycle t+MUL_LAT.
module mul16_cell #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [31:0] stage [MUL_LAT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= 32'(a) * 32'(b);
            for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 multiply sequencer built around one shared pipelined
// 16x16 cell; produces MUL (low word) and MULX* (high word) results.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | ready for a request; accept latches op/operands
// ST_ISSUE   | feed partial product k=cnt into the cell, one per cycle
// ST_DRAIN   | wait MUL_LAT cycles for the last products to accumulate
// ST_CORRECT | apply signed correction to the high word
// ST_DONE    | present result until rsp_ready
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int OP_W    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_src1,
    input  logic [31:0]     req_src2,
    input  logic            abort,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_result
);

    mul_state_t      state, n_state;
    logic            started;
    logic [OP_W-1:0] op_q;
    logic [31:0]     a_q, b_q;
    logic [1:0]      cnt;
    logic [63:0]     acc;
    logic            tag_v [MUL_LAT];
    logic [1:0]      tag_k [MUL_LAT];
    logic [15:0]     cell_a, cell_b;
    logic [31:0]     cell_p;
    logic [31:0]     corr;
    logic            accept, issue, is_mul;
    logic [1:0]      last_k;

    assign is_mul = (op_q == MUL_OP_MUL);
    assign last_k = is_mul ? 2'd2 : 2'd3;
    assign accept = req_valid && req_ready && !abort;

    // cnt[0] selects the high half of A, cnt[1] the high half of B.
    assign cell_a = cnt[0] ? a_q[31:16] : a_q[15:0];
    assign cell_b = cnt[1] ? b_q[31:16] : b_q[15:0];

    mul16_cell #(.MUL_LAT(MUL_LAT)) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (cell_a),
        .b       (cell_b),
        .p       (cell_p)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= n_state;
    end

    always_comb begin
        n_state    = state;
        issue      = 1'b0;
        req_ready  = started && (state == ST_IDLE);
        rsp_valid  = 1'b0;
        rsp_result = '0;
        case (state)
            ST_IDLE:    if (accept) n_state = ST_ISSUE;
            ST_ISSUE: begin
                issue = !abort;
                if (cnt == last_k) n_state = ST_DRAIN;
            end
            ST_DRAIN:   if (cnt == 2'd0) n_state = ST_CORRECT;
            ST_CORRECT: n_state = ST_DONE;
            ST_DONE: begin
                rsp_valid  = !abort;
                rsp_result = is_mul ? acc[31:0] : acc[63:32];
                if (rsp_ready) n_state = ST_IDLE;
            end
            default:    n_state = ST_IDLE;
        endcase
        if (abort) n_state = ST_IDLE;
    end

    always_comb begin
        corr = '0;
        if (op_q == MUL_OP_MULXSS)
            corr = (a_q[31] ? b_q : 32'd0) + (b_q[31] ? a_q : 32'd0);
        else if (op_q == MUL_OP_MULXSU)
            corr = a_q[31] ? b_q : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            acc     <= '0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_src1;
                b_q  <= req_src2;
                cnt  <= '0;
            end else if (state == ST_ISSUE) begin
                cnt <= (cnt == last_k) ? 2'(MUL_LAT - 1) : cnt + 2'd1;
            end else if (state == ST_DRAIN && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end

            if (accept)
                acc <= '0;
            else if (state == ST_CORRECT)
                acc[63:32] <= acc[63:32] - corr;
            else if (tag_v[MUL_LAT-1])
                acc <= acc + (64'(cell_p) << pp_shift(tag_k[MUL_LAT-1]));
        end
    end

    // Tags travel alongside the cell pipeline; abort flushes them so stale
    // products never reach the accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_v[i] <= 1'b0;
                tag_k[i] <= '0;
            end
        end else begin
            tag_v[0] <= issue;
            tag_k[0] <= cnt;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_k[i] <= tag_k[i-1];
            end
            if (abort)
                for (int i = 0; i < MUL_LAT; i++) tag_v[i] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner cases plus random ops
// compared against a plain 64-bit arithmetic reference model.
module tb_mul_seq_ctrl;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        abort;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    int n_vec = 0;
    int n_err = 0;

    mul_seq_ctrl #(.MUL_LAT(LAT), .OP_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .abort      (abort),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0:    p = {32'd0, a} * {32'd0, b};
            2'd1:    p = {32'd0, a} * {32'd0, b};
            2'd2:    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            default: p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int cyc = 0;
        while (!req_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Issue one request and wait for its response; returns cycles from the
    // accept cycle to the first rsp_valid cycle.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int lat;
        logic [31:0] exp;
        exp = ref_mul(op, a, b);
        start_op(op, a, b, lat);
        chk("latency", 32'(lat), 32'((op == 2'd0 ? 3 : 4) + LAT + 2));
        chk("result", rsp_result, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_result", rsp_result, exp);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0000_0000;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_src1  = '0;
        req_src2  = '0;
        abort     = 1'b0;
        rsp_ready = 1'b0;

        tick();
        tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_req_ready_pre_edge", {31'd0, req_ready}, 32'd0);
        tick();
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // Directed cases
        run_op(2'd0, 32'h0001_0002, 32'h0003_0004, 0);
        chk("model_mul_small", ref_mul(2'd0, 32'h0001_0002, 32'h0003_0004), 32'h000A_0008);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'd2, 32'h8000_0000, 32'h0000_0001, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        run_op(2'd3, 32'h0000_0002, 32'hFFFF_FFFF, 0);

        // Backpressure then back-to-back request
        run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        run_op(2'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);

        // Abort during ISSUE k=2
        wait_ready();
        req_valid = 1'b1; req_op = 2'd1; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        run_op(2'd1, 32'h0000_0003, 32'h0000_0005, 0);
        run_op(2'd0, 32'h0000_0003, 32'h0000_0005, 0);

        // Abort coinciding with the DONE handshake
        start_op(2'd2, 32'h0000_0007, 32'hFFFF_FFF0, lat);
        chk("pre_abort_valid", {31'd0, rsp_valid}, 32'd1);
        abort = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("abort_done_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        abort = 1'b0;
        rsp_ready = 1'b0;
        chk("abort_done_idle", {31'd0, req_ready}, 32'd1);
        chk("abort_done_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Abort in IDLE with req_valid: not accepted
        req_valid = 1'b1; req_op = 2'd0; req_src1 = 32'd9; req_src2 = 32'd9;
        abort = 1'b1;
        tick();
        req_valid = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("idle_abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("idle_abort_ready", {31'd0, req_ready}, 32'd1);
            tick();
        end

        // Reset mid-DRAIN (MUL: DRAIN in cycle 4 after accept)
        wait_ready();
        req_valid = 1'b1; req_op = 2'd0; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'h0000_0003;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid_result", rsp_result, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_mid_release", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end

        // Reset while a result is presented
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("pre_rst_result", rsp_result, 32'hFFFF_FFFE);
        reset_n = 1'b0;
        #1;
        chk("rst_done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_done_result", rsp_result, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer that produces 32x32 multiply results for the Nios II custom/ALU path using one shared pipelined 16x16 unsigned multiplier cell.
- Issues up to four 16x16 partial products, accumulates them into a 64-bit sum, and applies signed correction to the high word.
- Sits between the CPU execute stage (valid/ready request) and the hardware multiplier block.
- Ops: MUL (low 32), MULXUU, MULXSS and MULXSU (high 32).

Parameters:
- MUL_LAT, 1, pipeline latency of the 16x16 cell in cycles (legal values 1 or 2).
- OP_W, 2, width of the op code.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  2  00 MUL, 01 MULXUU, 10 MULXSS, 11 MULXSU
- req_src1  in  32  operand A
- req_src2  in  32  operand B
- abort  in  1  synchronous flush; drops any operation in flight
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_result  out  32  result word

Behaviour:
- Reset values: req_ready=0 while reset_n=0 and 1 from the first clk edge after release; rsp_valid=0; rsp_result=0; state=IDLE; accumulator=0.
- States: IDLE, ISSUE, DRAIN, CORRECT, DONE.
- IDLE: req_ready=1. On accept, latch op and operands, clear the 64-bit accumulator, set k=0, go to ISSUE.
- ISSUE: req_ready=0. One partial product per cycle, k=0..N-1:
  - k0 = A[15:0]*B[15:0], shift 0
  - k1 = A[31:16]*B[15:0], shift 16
  - k2 = A[15:0]*B[31:16], shift 16
  - k3 = A[31:16]*B[31:16], shift 32
  - N=3 for MUL (k3 skipped), N=4 otherwise.
- Accumulation: a product issued in cycle t is added (zero-extended, shifted) into the accumulator in cycle t+MUL_LAT. All sums are mod 2^64.
- DRAIN: lasts MUL_LAT cycles to absorb the remaining products.
- CORRECT: 1 cycle, taken for every op so latency is fixed.
  - MULXSS: hi -= (A[31]?B:0) + (B[31]?A:0), mod 2^32.
  - MULXSU: hi -= (A[31]?B:0).
  - MUL and MULXUU: no change.
- DONE:
  - rsp_valid=1; rsp_result = acc[31:0] for MUL, acc[63:32] otherwise.
  - rsp_result is held stable while rsp_ready=0.
  - On rsp_ready: return to IDLE. rsp_valid=0 and req_ready=1 in the next cycle.
- Latency: accept cycle to first rsp_valid cycle = N + MUL_LAT + 2. With MUL_LAT=1 that is 6 cycles for MUL and 7 for MULX*.
- Throughput: one op in flight; a new accept is possible the cycle after the response handshake.
- Abort:
  - Any state except IDLE goes to IDLE next cycle; rsp_valid is forced 0 that cycle and no response is produced.
  - Products still in the cell pipeline are ignored, because the accumulator is cleared on the next accept.
  - Abort in the same cycle as a DONE rsp_ready handshake: abort wins and the result counts as not delivered.
  - Abort in IDLE together with req_valid: the request is not accepted.
- Reset asserted mid-operation: all state and outputs go asynchronously to their reset values.
- Operand values: no special cases; all 0s and all 1s are valid inputs.

Decomposition:
- Shared package mul_pkg:
  - op-code constants MUL_OP_MUL, MUL_OP_MULXUU, MUL_OP_MULXSS, MUL_OP_MULXSU
  - state enum values
  - partial-product shift table
- Sub-module mul16_cell: 16x16 unsigned multiplier with 32-bit result and MUL_LAT registered stages.
  - Ports: clk, reset_n; the registers clear on reset.
  - Inferred multiply, or a vendor mult-add primitive when targeting Cyclone.

Test Plan:
- MUL with A=0x00010002, B=0x00030004 -> rsp_result=0x000A0008, rsp_valid asserted 6 cycles after accept (MUL_LAT=1).
- MULXUU with A=B=0xFFFFFFFF -> 0xFFFFFFFE, 7 cycles after accept; MUL with the same operands -> 0x00000001.
- MULXSS:
  - A=B=0xFFFFFFFF -> 0x00000000.
  - A=B=0x80000000 -> 0x40000000.
  - A=0x80000000, B=0x00000001 -> 0xFFFFFFFF.
- MULXSU:
  - A=0xFFFFFFFF, B=0x00000002 -> 0xFFFFFFFF.
  - A=0x00000002, B=0xFFFFFFFF -> 0x00000001.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_result stable and req_ready=0 throughout; after the handshake, req_ready=1 the next cycle; a back-to-back request then gives the correct result.
- Abort and reset:
  - Abort during ISSUE k=2, then MULXUU 0x00000003*0x00000005 -> 0x00000000; the following MUL on the same operands -> 0x0000000F, with no stale response.
  - reset_n low mid-DRAIN -> rsp_valid=0 and rsp_result=0 immediately; req_ready=1 after release.
